instr_mem_loader: RTL and testbench

// - Instruction-side partner of the 19-bit CPU: serves `instruction` for the CPU's `pc` and owns the program image.
// - Accepts a program as a valid/ready word stream and de-obfuscates each word (XOR KEY) before storing it.
// - Holds the CPU in reset while loading. Releases it once the last word is stored.

---
 rtl/cpu19_pkg.sv | 29 ++
 rtl/instr_mem_loader_if.sv | 30 +++
 rtl/instr_mem_loader_ram.sv | 25 ++
 rtl/instr_mem_loader.sv | 108 ++++++++++
 tb/tb_instr_mem_loader.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU and its instruction-side loader.
package cpu19_pkg;

  localparam int unsigned DATA_W = 19;

  // Opcodes occupy the top four bits of an instruction word.
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SHL   = 4'b0101;
  localparam logic [3:0] OP_SHR   = 4'b0110;
  localparam logic [3:0] OP_XORK2 = 4'b0111;
  localparam logic [3:0] OP_NOP   = 4'b1000;

  // Obfuscation mask stripped from every loaded word.
  localparam logic [DATA_W-1:0] DEFAULT_KEY = 19'h7FFFF;

  // Harmless NOP word served when no valid instruction is available.
  localparam logic [DATA_W-1:0] DEFAULT_OOR_WORD = {OP_NOP, {(DATA_W - 4){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Program-load stream: start pulse plus a valid/ready word channel.
interface instr_mem_loader_if #(
  parameter int unsigned DATA_W = cpu19_pkg::DATA_W
) ();

  logic              load_start;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

  // Program source side.
  modport master (
    output load_start,
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  // Loader side.
  modport slave (
    input  load_start,
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );

endinterface

// File: rtl/instr_mem_loader_ram.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module instr_ram #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [(1 << ADDR_W)];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Loads an obfuscated program stream into instruction memory, holds the CPU in
// reset while loading and serves instructions for the CPU's pc once running.
module instr_mem_loader
  import cpu19_pkg::*;
#(
  parameter int unsigned       DATA_W   = cpu19_pkg::DATA_W,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [DATA_W-1:0] KEY      = cpu19_pkg::DEFAULT_KEY,
  parameter logic [DATA_W-1:0] OOR_WORD = cpu19_pkg::DEFAULT_OOR_WORD
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loader_if.slave    ld,
  input  logic [DATA_W-1:0]    pc,
  output logic [DATA_W-1:0]    instruction,
  output logic                 cpu_reset,
  output logic                 run,
  output logic [ADDR_W:0]      load_count,
  output logic                 err_overflow
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] OneCnt   = (ADDR_W + 1)'(1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              cpu_reset_q;
  logic              xfer;
  logic              full;
  logic [DATA_W-1:0] ram_rdata;

  assign full          = (count_q == DepthCnt);
  assign ld.load_ready = (state_q == LOAD) && !full;
  assign xfer          = ld.load_valid && ld.load_ready;

  // Next-state, counter and sticky-error logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (ld.load_start) state_d = LOAD;
      end
      LOAD: begin
        // load_start is deliberately ignored here.
        if (full && ld.load_valid) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (xfer) begin
          count_d = count_q + OneCnt;
          if (ld.load_last) state_d = RUN;
        end
      end
      RUN: begin
        if (ld.load_start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    // A fresh load always starts from an empty count and a clear error.
    if (state_q != LOAD && state_d == LOAD) begin
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  // State, counter, error flag and registered CPU reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      cpu_reset_q <= (state_d != RUN);
    end
  end

  instr_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (ld.load_data ^ KEY),
    .raddr (pc[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Read mux: only words actually stored by the last load are visible.
  always_comb begin
    instruction = OOR_WORD;
    if (run && (pc < DATA_W'(count_q))) begin
      instruction = ram_rdata;
    end
  end

  assign run          = (state_q == RUN);
  assign cpu_reset    = cpu_reset_q;
  assign load_count   = count_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (full-size and 4-word instances).
module tb_instr_mem_loader;

  localparam int unsigned DW = 19;

  logic          clk;
  logic          reset;
  logic [DW-1:0] pc_a, pc_b;
  logic [DW-1:0] instr_a, instr_b;
  logic          cpu_reset_a, cpu_reset_b;
  logic          run_a, run_b;
  logic [8:0]    count_a;
  logic [2:0]    count_b;
  logic          err_a, err_b;

  int n_cmp = 0;
  int n_err = 0;

  instr_mem_loader_if #(.DATA_W(DW)) ifa ();
  instr_mem_loader_if #(.DATA_W(DW)) ifb ();

  instr_mem_loader #(.DATA_W(DW), .ADDR_W(8)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .ld           (ifa.slave),
    .pc           (pc_a),
    .instruction  (instr_a),
    .cpu_reset    (cpu_reset_a),
    .run          (run_a),
    .load_count   (count_a),
    .err_overflow (err_a)
  );

  instr_mem_loader #(.DATA_W(DW), .ADDR_W(2)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .ld           (ifb.slave),
    .pc           (pc_b),
    .instruction  (instr_b),
    .cpu_reset    (cpu_reset_b),
    .run          (run_b),
    .load_count   (count_b),
    .err_overflow (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pc_a = '0;
    pc_b = '0;
    ifa.load_start = 0; ifa.load_valid = 0; ifa.load_data = '0; ifa.load_last = 0;
    ifb.load_start = 0; ifb.load_valid = 0; ifb.load_data = '0; ifb.load_last = 0;
    #12;

    // Reset values.
    check_eq("rst_cpu_reset", 32'(cpu_reset_a), 32'd1);
    check_eq("rst_ready", 32'(ifa.load_ready), 32'd0);
    check_eq("rst_instr_pc0", 32'(instr_a), 32'h40000);
    pc_a = 19'd5; #1;
    check_eq("rst_instr_pc5", 32'(instr_a), 32'h40000);
    check_eq("rst_count", 32'(count_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);

    step();
    reset = 1'b0;
    step();

    // Start a load.
    ifa.load_start = 1;
    step();
    ifa.load_start = 0;
    check_eq("start_ready", 32'(ifa.load_ready), 32'd1);
    check_eq("start_run", 32'(run_a), 32'd0);

    // Three words with valid toggling every cycle.
    ifa.load_valid = 1; ifa.load_data = 19'h7FFFF;
    step();
    check_eq("bp_cnt_w0", 32'(count_a), 32'd1);
    ifa.load_valid = 0; ifa.load_data = 19'h11111;
    step();
    check_eq("bp_cnt_idle0", 32'(count_a), 32'd1);
    ifa.load_valid = 1; ifa.load_data = 19'h7FFFE;
    step();
    check_eq("bp_cnt_w1", 32'(count_a), 32'd2);
    ifa.load_valid = 0; ifa.load_last = 1;  // last without valid must be ignored
    step();
    check_eq("bp_cnt_idle1", 32'(count_a), 32'd2);
    check_eq("bp_last_novalid", 32'(run_a), 32'd0);
    ifa.load_valid = 1; ifa.load_data = 19'h0FFFF; ifa.load_last = 1;
    check_eq("pre_run_cpu_reset", 32'(cpu_reset_a), 32'd1);
    step();
    ifa.load_valid = 0; ifa.load_last = 0;
    check_eq("run_entered", 32'(run_a), 32'd1);
    check_eq("run_cpu_reset", 32'(cpu_reset_a), 32'd0);
    check_eq("run_count", 32'(count_a), 32'd3);
    check_eq("run_ready", 32'(ifa.load_ready), 32'd0);

    pc_a = 19'd0; #1; check_eq("rd_pc0", 32'(instr_a), 32'h00000);
    pc_a = 19'd1; #1; check_eq("rd_pc1", 32'(instr_a), 32'h00001);
    pc_a = 19'd2; #1; check_eq("rd_pc2", 32'(instr_a), 32'h70000);
    pc_a = 19'd3; #1; check_eq("rd_pc3_oor", 32'(instr_a), 32'h40000);
    pc_a = 19'h40001; #1; check_eq("rd_pc_hi_oor", 32'(instr_a), 32'h40000);

    // Restart from RUN.
    ifa.load_start = 1;
    step();
    ifa.load_start = 0;
    check_eq("restart_cpu_reset", 32'(cpu_reset_a), 32'd1);
    check_eq("restart_count", 32'(count_a), 32'd0);
    check_eq("restart_run", 32'(run_a), 32'd0);
    pc_a = 19'd1; #1;
    check_eq("restart_instr", 32'(instr_a), 32'h40000);

    // load_start during LOAD is ignored; the word in flight is stored.
    ifa.load_start = 1; ifa.load_valid = 1; ifa.load_data = 19'h12345;
    step();
    ifa.load_start = 0;
    check_eq("ign_count", 32'(count_a), 32'd1);
    check_eq("ign_ready", 32'(ifa.load_ready), 32'd1);
    ifa.load_data = 19'h00000; ifa.load_last = 1;
    step();
    ifa.load_valid = 0; ifa.load_last = 0;
    check_eq("ign_run", 32'(run_a), 32'd1);
    check_eq("ign_count2", 32'(count_a), 32'd2);
    pc_a = 19'd0; #1; check_eq("ign_rd0", 32'(instr_a), 32'h6DCBA);
    pc_a = 19'd1; #1; check_eq("ign_rd1", 32'(instr_a), 32'h7FFFF);

    // Async reset mid-load after two words.
    ifa.load_start = 1;
    step();
    ifa.load_start = 0; ifa.load_valid = 1; ifa.load_data = 19'h00001;
    step();
    ifa.load_data = 19'h00002;
    step();
    ifa.load_valid = 0;
    check_eq("mid_count", 32'(count_a), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_cpu_reset", 32'(cpu_reset_a), 32'd1);
    check_eq("arst_ready", 32'(ifa.load_ready), 32'd0);
    check_eq("arst_count", 32'(count_a), 32'd0);
    check_eq("arst_run", 32'(run_a), 32'd0);
    check_eq("arst_instr", 32'(instr_a), 32'h40000);
    step();
    reset = 1'b0;
    step();
    check_eq("arst_stays_idle", 32'(ifa.load_ready), 32'd0);

    // Overflow on the 4-word instance.
    ifb.load_start = 1;
    step();
    ifb.load_start = 0;
    ifb.load_valid = 1;
    ifb.load_data = 19'h7FFEE; step();
    ifb.load_data = 19'h7FFDD; step();
    ifb.load_data = 19'h7FFCC; step();
    ifb.load_data = 19'h7FFBB; step();
    check_eq("ovf_count_full", 32'(count_b), 32'd4);
    check_eq("ovf_ready_drop", 32'(ifb.load_ready), 32'd0);
    check_eq("ovf_err_pre", 32'(err_b), 32'd0);
    ifb.load_data = 19'h00000;
    step();
    ifb.load_valid = 0;
    check_eq("ovf_err", 32'(err_b), 32'd1);
    check_eq("ovf_run", 32'(run_b), 32'd0);
    check_eq("ovf_cpu_reset", 32'(cpu_reset_b), 32'd1);
    check_eq("ovf_count_sat", 32'(count_b), 32'd4);
    check_eq("ovf_mem0", 32'(dut_b.u_ram.mem[0]), 32'h00011);
    check_eq("ovf_mem1", 32'(dut_b.u_ram.mem[1]), 32'h00022);
    check_eq("ovf_mem2", 32'(dut_b.u_ram.mem[2]), 32'h00033);
    check_eq("ovf_mem3", 32'(dut_b.u_ram.mem[3]), 32'h00044);
    step();
    check_eq("ovf_idle_ready", 32'(ifb.load_ready), 32'd0);
    check_eq("ovf_err_sticky", 32'(err_b), 32'd1);
    ifb.load_start = 1;
    step();
    ifb.load_start = 0;
    check_eq("ovf_reload_err", 32'(err_b), 32'd0);
    check_eq("ovf_reload_count", 32'(count_b), 32'd0);
    check_eq("ovf_reload_ready", 32'(ifb.load_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
